// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the ALU and its multi-cycle
// multiply/divide stage.
//
// Contents:
//   WORD_SIZE        operand width
//   ALU_* codes      6-bit ALU_Sel operation encoding
//   muldiv_state_t   sequencer states for seq_mul_div
//   ITER_COUNT       divide iterations per operation
//   MUL_ITER_COUNT   multiply iterations per operation
//   BOOTH_BITS       width of the Booth recoder input window
//   BOOTH_SHIFT      arithmetic shift applied per multiply iteration
//   booth_sel_t      partial-product select produced by booth_recode
//
// Optional feature macro: MULDIV_RADIX4_EN.
// When it is defined, multiply retires two multiplier bits per iteration
// (radix-4 Booth). When it is undefined, multiply uses radix-2 Booth.
package alu_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [5:0] ALU_ADD      = 6'd0;
  localparam logic [5:0] ALU_SUB      = 6'd1;
  localparam logic [5:0] ALU_DIV_COMB = 6'd2;
  localparam logic [5:0] ALU_AND      = 6'd3;
  localparam logic [5:0] ALU_OR       = 6'd4;
  localparam logic [5:0] ALU_XOR      = 6'd5;
  localparam logic [5:0] ALU_MUL      = 6'd6;
  localparam logic [5:0] ALU_DIV      = 6'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam int ITER_COUNT = WORD_SIZE;

`ifdef MULDIV_RADIX4_EN
  localparam int MUL_ITER_COUNT = WORD_SIZE / 2;
  localparam int BOOTH_BITS     = 3;
  localparam int BOOTH_SHIFT    = 2;
`else
  localparam int MUL_ITER_COUNT = WORD_SIZE;
  localparam int BOOTH_BITS     = 2;
  localparam int BOOTH_SHIFT    = 1;
`endif

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_POS  = 3'd1,
    BOOTH_NEG  = 3'd2,
    BOOTH_POS2 = 3'd3,
    BOOTH_NEG2 = 3'd4
  } booth_sel_t;

endpackage

// File: rtl/booth_recode.sv
// booth_recode: combinational Booth digit recoder.
//
// Ports:
//   bits  in   BOOTH_BITS  multiplier window {q[0], q-1}
//                          (or {q[1], q[0], q-1} when radix-4 is enabled)
//   sel   out  booth_sel_t partial product to add: 0, +M or -M
//                          (and +2M or -2M when radix-4 is enabled)
//
// Optional feature macro: MULDIV_RADIX4_EN selects the 3-bit radix-4 table.
module booth_recode
  import alu_pkg::*;
(
  input  logic [BOOTH_BITS-1:0] bits,
  output booth_sel_t            sel
);

`ifdef MULDIV_RADIX4_EN
  // The window {q[i+1], q[i], q[i-1]} encodes a digit in the range -2..+2.
  always_comb begin
    sel = BOOTH_ZERO;
    case (bits)
      3'b001, 3'b010: sel = BOOTH_POS;
      3'b011:         sel = BOOTH_POS2;
      3'b100:         sel = BOOTH_NEG2;
      3'b101, 3'b110: sel = BOOTH_NEG;
      default:        sel = BOOTH_ZERO;
    endcase
  end
`else
  // The pair {q[0], q-1} encodes the digit q-1 - q[0].
  always_comb begin
    sel = BOOTH_ZERO;
    case (bits)
      2'b01:   sel = BOOTH_POS;
      2'b10:   sel = BOOTH_NEG;
      default: sel = BOOTH_ZERO;
    endcase
  end
`endif

endmodule

// File: rtl/seq_mul_div.sv
// seq_mul_div: multi-cycle signed multiply/divide stage that sits beside the
// single-cycle ALU. The control unit raises start with ALU_Sel = MUL/DIV and
// stalls on busy until done pulses. Z_high/Z_low then hold the result until
// the next accepted operation reaches its FIX edge.
//
// Ports:
//   clock     in   1          rising-edge clock
//   clear     in   1          synchronous active-high reset
//   start     in   1          request, only looked at in IDLE
//   ALU_Sel   in   6          operation; only OP_MUL / OP_DIV are accepted
//   A         in   word_size  multiplicand / dividend (two's complement)
//   B         in   word_size  multiplier / divisor (two's complement)
//   busy      out  1          operation in flight
//   done      out  1          one-cycle pulse; Z valid from this cycle
//   Z_high    out  word_size  MUL: product high word; DIV: remainder
//   Z_low     out  word_size  MUL: product low word;  DIV: quotient
//   div_zero  out  1          the last DIV had a zero divisor
//
// Optional feature macro: MULDIV_RADIX4_EN (radix-4 Booth multiply, with
// half the multiply iterations; divide is the same in both builds).
module seq_mul_div
  import alu_pkg::*;
#(
  parameter int          word_size = WORD_SIZE,
  parameter logic [5:0]  OP_MUL    = ALU_MUL,
  parameter logic [5:0]  OP_DIV    = ALU_DIV
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [5:0]           ALU_Sel,
  input  logic [word_size-1:0] A,
  input  logic [word_size-1:0] B,
  output logic                 busy,
  output logic                 done,
  output logic [word_size-1:0] Z_high,
  output logic [word_size-1:0] Z_low,
  output logic                 div_zero
);

  localparam int div_iters = word_size;
  localparam int mul_iters = word_size / BOOTH_SHIFT;
  localparam int cnt_w     = $clog2(word_size + 1);
  // Two guard bits above the sign-extended multiplicand keep +/-2M
  // partial sums (including M = most negative) from overflowing.
  localparam int acc_w     = word_size + 3;
  localparam int booth_w   = acc_w + word_size + 1;

  muldiv_state_t state, state_next;

  logic [cnt_w-1:0]        cnt;
  logic                    op_div;
  logic                    dz_pend;
  logic                    sign_a;
  logic                    sign_b;
  logic [word_size:0]      m;
  logic signed [acc_w-1:0] acc;
  logic [word_size-1:0]    q;
  logic                    qm1;

  logic                    accept;
  logic                    accept_dz;
  logic [cnt_w-1:0]        last_iter;
  booth_sel_t              booth_sel;
  logic [BOOTH_BITS-1:0]   booth_bits;
  logic signed [acc_w-1:0] m_ext;
  logic signed [acc_w-1:0] pp;
  logic signed [acc_w-1:0] acc_sum;
  logic signed [booth_w-1:0] booth_shifted;
  logic [word_size:0]      rem_shift;
  logic [word_size:0]      trial;

  function automatic logic [word_size-1:0] magnitude(input logic [word_size-1:0] v);
    return v[word_size-1] ? -v : v;
  endfunction

  assign accept    = (state == IDLE) && start && ((ALU_Sel == OP_MUL) || (ALU_Sel == OP_DIV));
  assign accept_dz = (ALU_Sel == OP_DIV) && (B == '0);
  assign last_iter = op_div ? cnt_w'(div_iters - 1) : cnt_w'(mul_iters - 1);

`ifdef MULDIV_RADIX4_EN
  assign booth_bits = {q[1], q[0], qm1};
`else
  assign booth_bits = {q[0], qm1};
`endif

  booth_recode u_booth_recode (
    .bits (booth_bits),
    .sel  (booth_sel)
  );

  // Multiply step: add the selected partial product into the accumulator,
  // then arithmetic-shift the whole {acc, q, q-1} register right.
  assign m_ext = signed'({{(acc_w - word_size - 1){m[word_size]}}, m});

  always_comb begin
    pp = '0;
    case (booth_sel)
      BOOTH_POS:  pp = m_ext;
      BOOTH_NEG:  pp = -m_ext;
      BOOTH_POS2: pp = m_ext <<< 1;
      BOOTH_NEG2: pp = -(m_ext <<< 1);
      default:    pp = '0;
    endcase
  end

  assign acc_sum       = acc + pp;
  assign booth_shifted = $signed({acc_sum, q, qm1}) >>> BOOTH_SHIFT;

  // Restoring divide step on magnitudes: shift the next dividend bit into
  // the partial remainder and keep the trial subtraction if it did not borrow.
  assign rem_shift = {acc[word_size-1:0], q[word_size-1]};
  assign trial     = rem_shift - m;

  // State register.
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs. A zero divisor skips RUN entirely.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = accept_dz ? FIX : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == last_iter) begin
          state_next = FIX;
        end
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operands are captured on the accept edge so A/B/ALU_Sel may
  // change afterwards. For DIV, acc holds the partial remainder and q the
  // shifting dividend/quotient; for a zero divisor q keeps raw A for Z_high.
  always_ff @(posedge clock) begin
    if (clear) begin
      cnt      <= '0;
      op_div   <= 1'b0;
      dz_pend  <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      m        <= '0;
      acc      <= '0;
      q        <= '0;
      qm1      <= 1'b0;
      Z_high   <= '0;
      Z_low    <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= '0;
            acc      <= '0;
            qm1      <= 1'b0;
            op_div   <= (ALU_Sel == OP_DIV);
            dz_pend  <= accept_dz;
            sign_a   <= A[word_size-1];
            sign_b   <= B[word_size-1];
            div_zero <= 1'b0;
            if (ALU_Sel == OP_DIV) begin
              q <= accept_dz ? A : magnitude(A);
              m <= {1'b0, magnitude(B)};
            end else begin
              q <= B;
              m <= {A[word_size-1], A};
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op_div) begin
            acc <= {{(acc_w - word_size - 1){1'b0}}, (trial[word_size] ? rem_shift : trial)};
            q   <= {q[word_size-2:0], ~trial[word_size]};
          end else begin
            {acc, q, qm1} <= booth_shifted;
          end
        end
        FIX: begin
          if (dz_pend) begin
            Z_low    <= '1;
            Z_high   <= q;
            div_zero <= 1'b1;
          end else if (op_div) begin
            // Truncating division: quotient sign from sign(A)^sign(B),
            // remainder follows the dividend.
            Z_low  <= (sign_a ^ sign_b) ? -q : q;
            Z_high <= sign_a ? -acc[word_size-1:0] : acc[word_size-1:0];
          end else begin
            Z_high <= acc[word_size-1:0];
            Z_low  <= q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_div.sv
// tb_seq_mul_div: self-checking bench for seq_mul_div. Expected results are
// computed by a reference model when a start is driven, queued, and compared
// when done pulses. Build with MULDIV_RADIX4_EN to check the radix-4 variant.
module tb_seq_mul_div;
  import alu_pkg::*;

`ifdef MULDIV_RADIX4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [5:0]  ALU_Sel;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Z_high;
  logic [31:0] Z_low;
  logic        div_zero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int doneCount  = 0;
  int acceptCyc  = 0;

  seq_mul_div dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .ALU_Sel  (ALU_Sel),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .Z_high   (Z_high),
    .Z_low    (Z_low),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  // Free-running cycle counter used to measure start-to-done latency.
  always @(posedge clock) cyc <= cyc + 1;

  // Counts every done pulse so aborted operations can be shown to never finish.
  always @(negedge clock) if (done === 1'b1) doneCount <= doneCount + 1;

  function automatic exp_t model(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint pa;
    longint pb;
    longint p;
    int     sa;
    int     sbv;
    e.dz = 1'b0;
    if (sel == ALU_MUL) begin
      pa    = longint'($signed(a));
      pb    = longint'($signed(b));
      p     = pa * pb;
      e.hi  = p[63:32];
      e.lo  = p[31:0];
      e.lat = MUL_LAT;
    end else if (b == 32'd0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.dz  = 1'b1;
      e.lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.hi  = 32'd0;
      e.lo  = 32'h8000_0000;
      e.lat = DIV_LAT;
    end else begin
      sa    = $signed(a);
      sbv   = $signed(b);
      e.lo  = sa / sbv;
      e.hi  = sa % sbv;
      e.lat = DIV_LAT;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one start cycle; operands are scrambled right after the accept edge.
  task automatic applyStimulus(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b,
                               input bit expectResult);
    ALU_Sel = sel;
    A       = a;
    B       = b;
    start   = 1'b1;
    step();
    acceptCyc = cyc;
    start   = 1'b0;
    A       = $urandom;
    B       = $urandom;
    ALU_Sel = 6'($urandom_range(0, 63));
    if (expectResult) sbq.push_back(model(sel, a, b));
  endtask

  // Waits (bounded) for done, then compares against the queued expectation.
  task automatic waitResult(input string tag);
    int   guard  = 0;
    bit   busyOk = 1'b1;
    exp_t e;
    while (done !== 1'b1 && guard < 200) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      step();
      guard++;
    end
    checkOutput({tag, ".doneSeen"}, 64'(done), 64'd1);
    checkOutput({tag, ".queueDepth"}, 64'(sbq.size()), 64'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      checkOutput({tag, ".latency"}, 64'(cyc - acceptCyc), 64'(e.lat));
      checkOutput({tag, ".busyHeld"}, 64'(busyOk), 64'd1);
      checkOutput({tag, ".busyAtDone"}, 64'(busy), 64'd0);
      checkOutput({tag, ".Z_high"}, 64'(Z_high), 64'(e.hi));
      checkOutput({tag, ".Z_low"}, 64'(Z_low), 64'(e.lo));
      checkOutput({tag, ".div_zero"}, 64'(div_zero), 64'(e.dz));
    end
    step();
    checkOutput({tag, ".donePulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int doneBefore;
    logic [31:0] holdHi;
    logic [31:0] holdLo;

    clear   = 1'b1;
    start   = 1'b0;
    ALU_Sel = 6'd0;
    A       = 32'd0;
    B       = 32'd0;
    repeat (3) step();
    clear = 1'b0;
    step();
    $display("[TB] reset state");
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.done", 64'(done), 64'd0);
    checkOutput("reset.Z_high", 64'(Z_high), 64'd0);
    checkOutput("reset.Z_low", 64'(Z_low), 64'd0);
    checkOutput("reset.div_zero", 64'(div_zero), 64'd0);

    $display("[TB] directed multiplies");
    applyStimulus(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1);
    checkOutput("mul7x-3.constHi", 64'(sbq[0].hi), 64'h0000_0000_FFFF_FFFF);
    waitResult("mul7x-3");
    checkOutput("mul7x-3.tableLo", 64'(Z_low), 64'h0000_0000_FFFF_FFEB);

    applyStimulus(ALU_MUL, 32'h8000_0000, 32'h8000_0000, 1'b1);
    waitResult("mulMinxMin");
    checkOutput("mulMinxMin.tableHi", 64'(Z_high), 64'h0000_0000_4000_0000);

    $display("[TB] directed divides");
    applyStimulus(ALU_DIV, 32'd100, 32'hFFFF_FFF9, 1'b1);
    waitResult("div100/-7");
    checkOutput("div100/-7.tableLo", 64'(Z_low), 64'h0000_0000_FFFF_FFF2);
    checkOutput("div100/-7.tableHi", 64'(Z_high), 64'd2);

    applyStimulus(ALU_DIV, 32'hFFFF_FF9C, 32'd7, 1'b1);
    waitResult("div-100/7");
    checkOutput("div-100/7.tableHi", 64'(Z_high), 64'h0000_0000_FFFF_FFFE);

    applyStimulus(ALU_DIV, 32'h0000_1234, 32'd0, 1'b1);
    waitResult("divByZero");
    checkOutput("divByZero.tableHi", 64'(Z_high), 64'h0000_0000_0000_1234);
    checkOutput("divByZero.flagHeld", 64'(div_zero), 64'd1);

    applyStimulus(ALU_DIV, 32'd9, 32'd3, 1'b1);
    checkOutput("div9/3.flagClearedAtAccept", 64'(div_zero), 64'd0);
    waitResult("div9/3");

    applyStimulus(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    waitResult("divMin/-1");

    $display("[TB] start while busy is ignored");
    applyStimulus(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1);
    repeat (5) step();
    ALU_Sel = ALU_MUL;
    A       = 32'd1000;
    B       = 32'd1000;
    start   = 1'b1;
    step();
    start   = 1'b0;
    waitResult("mulIgnoredStart");

    $display("[TB] unsupported op in IDLE");
    holdHi = Z_high;
    holdLo = Z_low;
    ALU_Sel = ALU_AND;
    A       = 32'd5;
    B       = 32'd6;
    start   = 1'b1;
    step();
    start   = 1'b0;
    checkOutput("opAnd.busy", 64'(busy), 64'd0);
    step();
    checkOutput("opAnd.busyLater", 64'(busy), 64'd0);
    checkOutput("opAnd.done", 64'(done), 64'd0);
    checkOutput("opAnd.holdHi", 64'(Z_high), 64'h0000_0000_FFFF_FFFF);
    checkOutput("opAnd.holdLo", 64'(Z_low), 64'(holdLo));
    checkOutput("opAnd.holdHiSame", 64'(Z_high), 64'(holdHi));

    $display("[TB] clear during a divide");
    doneBefore = doneCount;
    applyStimulus(ALU_DIV, 32'd12345, 32'd17, 1'b0);
    repeat (9) step();
    checkOutput("abort.busyBefore", 64'(busy), 64'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    checkOutput("abort.busy", 64'(busy), 64'd0);
    checkOutput("abort.done", 64'(done), 64'd0);
    checkOutput("abort.Z_high", 64'(Z_high), 64'd0);
    checkOutput("abort.Z_low", 64'(Z_low), 64'd0);
    checkOutput("abort.div_zero", 64'(div_zero), 64'd0);
    repeat (40) step();
    checkOutput("abort.noDonePulse", 64'(doneCount), 64'(doneBefore));
    checkOutput("abort.stillIdle", 64'(busy), 64'd0);

    applyStimulus(ALU_MUL, 32'd2, 32'd3, 1'b1);
    waitResult("mul2x3");
    checkOutput("mul2x3.tableLo", 64'(Z_low), 64'd6);

    $display("[TB] random operands");
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (i % 3 == 2) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i % 4 == 3) rb = -rb;
      applyStimulus((i % 2 == 0) ? ALU_MUL : ALU_DIV, ra, rb, 1'b1);
      waitResult((i % 2 == 0) ? "randMul" : "randDiv");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_mul_div.md
Name: seq_mul_div

Overview:
- Multi-cycle signed multiply/divide stage beside the single-cycle ALU. Fed from the same A/B operand buses and the same 6-bit operation select.
- Extends the select encoding with MUL=6 and DIV=7.
- Produces the 64-bit result pair (high/low) that the downstream Z result register captures.
- Uses a start/busy/done handshake so the control unit stalls until the result is valid.

Parameters:
- word_size, 32, operand width; results are 2*word_size across Z_high/Z_low.
- OP_MUL, 6, ALU_Sel code for signed multiply.
- OP_DIV, 7, ALU_Sel code for signed divide.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- ALU_Sel  in  6  operation; only OP_MUL/OP_DIV accepted
- A  in  word_size  multiplicand / dividend (two's complement)
- B  in  word_size  multiplier / divisor (two's complement)
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; Z outputs valid from this cycle
- Z_high  out  word_size  MUL: product[63:32]; DIV: remainder
- Z_low  out  word_size  MUL: product[31:0]; DIV: quotient
- div_zero  out  1  set with done when a DIV had B==0

Behaviour:
- Clock and reset: one clock, clock. Reset is synchronous and active-high on clear.
- Reset state: state=IDLE; busy=0, done=0, div_zero=0, Z_high=0, Z_low=0.
- clear mid-operation: abort; at the next edge return to the full reset state. No done is produced.
- States: IDLE -> RUN -> FIX -> DONE -> IDLE.
- IDLE:
  - start=1 with ALU_Sel in {6,7} at edge N: latch A, B and the op; iteration count=0; busy=1; next state RUN.
  - start with any other ALU_Sel: ignored, stay in IDLE.
- RUN: one iteration per edge, 32 iterations (edges N+1..N+32), then FIX.
  - MUL: radix-2 Booth. 65-bit {acc, Q, q-1} register; add/subtract multiplicand in acc, then arithmetic shift right by 1.
  - DIV: restoring divide on magnitudes |A| and |B|. 33-bit partial remainder; one quotient bit per iteration.
- FIX: at edge N+33, write Z_high/Z_low, assert done, drop busy; next state DONE.
  - MUL: write the product.
  - DIV: apply signs. Quotient is negated if sign(A)!=sign(B). Remainder takes the sign of A (truncating division).
- DONE: done=1 for exactly this one cycle; next edge returns to IDLE.
- Latency: done is high in the cycle after edge N+33.
- Holding and back-to-back: Z outputs hold until the next accepted start overwrites them at its FIX edge. A new start is accepted in the cycle after DONE.
- start while busy or in DONE: ignored; no queueing.
- Divide by zero: detected at the accept edge; skip RUN.
  - Next edge goes straight to FIX behaviour: Z_low=all ones, Z_high=A, div_zero=1, done at N+1.
  - div_zero clears at the next accepted start.
- DIV 0x80000000 / -1: Z_low=0x80000000, Z_high=0; no flag.
- Inputs A, B and ALU_Sel may change freely after the accept edge.

Optional Feature:
- Macro: MULDIV_RADIX4_EN.
- Defined: multiply uses radix-4 Booth with 16 RUN iterations, so MUL done arrives in the cycle after edge N+17. DIV is unchanged.
- Undefined: radix-2 as specified above.
- Results are bit-identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - WORD_SIZE.
  - ALU_Sel code constants: ADD=0, SUB=1, DIV_COMB=2, AND=3, OR=4, XOR=5, MUL=6, DIV=7.
  - muldiv_state_t enum (IDLE, RUN, FIX, DONE).
  - ITER_COUNT constant.
- One sub-module: booth_recode. Combinational; maps 2 bits (3 bits under the radix-4 macro) to a partial-product select of 0/+M/-M (and +/-2M under the macro).

Test Plan:
- MUL A=7, B=-3 (0xFFFFFFFD) -> Z_high=0xFFFFFFFF, Z_low=0xFFFFFFEB; done exactly 33 cycles after the start edge (17 with MULDIV_RADIX4_EN); busy high throughout.
- MUL A=B=0x80000000 -> Z_high=0x40000000, Z_low=0x00000000.
- DIV 100 / -7 -> Z_low=0xFFFFFFF2 (-14), Z_high=2. DIV -100 / 7 -> Z_low=0xFFFFFFF2, Z_high=0xFFFFFFFE (-2).
- DIV A=0x1234, B=0 -> div_zero=1, Z_low=0xFFFFFFFF, Z_high=0x1234, done 1 cycle after accept. A following DIV 9/3 clears div_zero and gives Z_low=3, Z_high=0.
- Pulse start with a MUL and new operands 5 cycles into a busy MUL -> ignored; the original result is returned. Start with ALU_Sel=3 in IDLE -> busy stays 0.
- Assert clear at cycle 10 of a DIV -> next cycle busy=0, done=0, Z=0. done never pulses for the aborted op. A new MUL 2*3 afterwards -> Z_low=6.
